// File: rtl/adder_pkg.sv
// Shared constants and FSM encoding for the bit-serial adder.
package adder_pkg;

  localparam int unsigned ADDER_WIDTH = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_e;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder built from two half-adder cells and an OR of their carries.
module full_adder_bit (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  logic hs1, hc1, hc2;

  // first half adder: operand bits
  assign hs1 = a ^ b;
  assign hc1 = a & b;

  // second half adder: partial sum plus incoming carry
  assign sum = hs1 ^ cin;
  assign hc2 = hs1 & cin;

  assign cout = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one operand bit pair per clock through a single
// full-adder cell, carry held in a flop, result collected LSB-first.
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e          state;
  logic [WIDTH-1:0] sha, shb, acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_cout;

  full_adder_bit u_fa (
    .sum  (fa_sum),
    .cout (fa_cout),
    .a    (sha[0]),
    .b    (shb[0]),
    .cin  (carry)
  );

  // New sum bit enters at the MSB; after WIDTH steps bit 0 has reached acc[0].
  assign acc_nxt = WIDTH'({fa_sum, acc} >> 1);

  // FSM, operand shifters, carry, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sha   <= '0;
      shb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sha   <= a;
            shb   <= b;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= fa_cout;
          sha   <= sha >> 1;
          shb   <= shb >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= acc_nxt;
            cout  <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) using a result scoreboard.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  logic [W:0]   sb[$];
  int           n_checks;
  int           n_pass;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d",
             n_pass, n_checks);
    $fatal(1);
  end

  // Drive one accepted request from an IDLE negedge; returns at the negedge after the accept.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    sb.push_back((W+1)'(av) + (W+1)'(bv));
    @(negedge clk);
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
  endtask

  // n=0 is the negedge after the accepting edge; done is due at n=W.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if ({busy, done, cout, sum} !== 11'h0) begin
      $display("FAIL reset_hold: got busy=%b done=%b cout=%b sum=%h, want all 0",
               busy, done, cout, sum);
    end else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, cout, sum} !== 11'h0) begin
      $display("FAIL reset_release_idle: got busy=%b done=%b cout=%b sum=%h, want all 0",
               busy, done, cout, sum);
    end else n_pass++;
  endtask

  task automatic test_basic;
    int         bad;
    logic [W:0] exp;
    launch(8'h35, 8'h4A);
    bad = 0;
    for (int i = 0; i < W; i++) begin
      if (!(busy === 1'b1 && done === 1'b0)) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0) $display("FAIL basic_busy_window: bad cycles=%0d, want 0", bad);
    else n_pass++;
    n_checks++;
    if (!(done === 1'b1 && busy === 1'b0)) begin
      $display("FAIL basic_done: got done=%b busy=%b, want done=1 busy=0", done, busy);
    end else n_pass++;
    exp = sb.pop_front();
    n_checks++;
    if ({cout, sum} !== exp) $display("FAIL basic_result: got %h, want %h", {cout, sum}, exp);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) $display("FAIL basic_done_width: got done=%b, want 0", done);
    else n_pass++;
  endtask

  task automatic test_ripple;
    int         n;
    logic [W:0] exp;
    launch(8'hFF, 8'h01);
    wait_done(n);
    n_checks++;
    if (n !== W) $display("FAIL ripple_latency: got %0d, want %0d", n, W);
    else n_pass++;
    exp = sb.pop_front();
    n_checks++;
    if ({cout, sum} !== exp || exp !== 9'h100) begin
      $display("FAIL ripple_result: got %h, want %h", {cout, sum}, 9'h100);
    end else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int         n;
    int         bad;
    logic [W:0] exp;
    launch(8'hFF, 8'hFF);
    wait_done(n);
    exp = sb.pop_front();
    n_checks++;
    if ({cout, sum} !== exp) $display("FAIL b2b_first: got %h, want %h", {cout, sum}, exp);
    else n_pass++;
    @(negedge clk);
    launch(8'h00, 8'h00);
    n   = 0;
    bad = 0;
    while (done !== 1'b1 && n < 50) begin
      if ({cout, sum} !== 9'h1FE) bad++;
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL b2b_hold: cycles with changed result=%0d, want 0", bad);
    else n_pass++;
    n_checks++;
    if (n !== W) $display("FAIL b2b_latency: got %0d, want %0d", n, W);
    else n_pass++;
    exp = sb.pop_front();
    n_checks++;
    if ({cout, sum} !== exp) $display("FAIL b2b_second: got %h, want %h", {cout, sum}, exp);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_start_held;
    int         n;
    logic [W:0] exp;
    a     = 8'h12;
    b     = 8'h34;
    start = 1'b1;
    sb.push_back(9'h046);
    @(negedge clk);
    a = 8'h77;
    b = 8'h77;
    wait_done(n);
    n_checks++;
    if (n !== W) $display("FAIL held_latency: got %0d, want %0d", n, W);
    else n_pass++;
    exp = sb.pop_front();
    n_checks++;
    if ({cout, sum} !== exp) $display("FAIL held_result: got %h, want %h", {cout, sum}, exp);
    else n_pass++;
    // DONE -> IDLE edge ignores start; the next edge re-accepts it.
    @(negedge clk);
    n_checks++;
    if (!(done === 1'b0 && busy === 1'b0)) begin
      $display("FAIL held_gap: got done=%b busy=%b, want 0 0", done, busy);
    end else n_pass++;
    sb.push_back(9'h0EE);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL held_reaccept: got busy=%b, want 1", busy);
    else n_pass++;
    wait_done(n);
    exp = sb.pop_front();
    n_checks++;
    if ({cout, sum} !== exp) $display("FAIL held_second: got %h, want %h", {cout, sum}, exp);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int         n;
    logic [W:0] exp;
    launch(8'h55, 8'hAA);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, cout, sum} !== 11'h0) begin
      $display("FAIL midreset_async: got busy=%b done=%b cout=%b sum=%h, want all 0",
               busy, done, cout, sum);
    end else n_pass++;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(8'h80, 8'h80);
    wait_done(n);
    n_checks++;
    if (n !== W) $display("FAIL midreset_latency: got %0d, want %0d", n, W);
    else n_pass++;
    exp = sb.pop_front();
    n_checks++;
    if ({cout, sum} !== exp || exp !== 9'h100) begin
      $display("FAIL midreset_result: got %h, want %h", {cout, sum}, 9'h100);
    end else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random;
    int           n;
    logic [W:0]   exp;
    logic [W-1:0] av, bv;
    for (int i = 0; i < 1000; i++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      launch(av, bv);
      wait_done(n);
      n_checks++;
      if (n !== W) $display("FAIL rand_latency[%0d]: got %0d, want %0d", i, n, W);
      else n_pass++;
      exp = sb.pop_front();
      n_checks++;
      if ({cout, sum} !== exp) begin
        $display("FAIL rand_result[%0d]: a=%h b=%h got %h, want %h", i, av, bv, {cout, sum}, exp);
      end else n_pass++;
      @(negedge clk);
      n_checks++;
      if (!(done === 1'b0 && busy === 1'b0)) begin
        $display("FAIL rand_done_width[%0d]: got done=%b busy=%b, want 0 0", i, done, busy);
      end else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    #2;
    test_reset();
    test_basic();
    test_ripple();
    test_back_to_back();
    test_start_held();
    test_reset_mid();
    test_random();
    n_checks++;
    if (sb.size() !== 0) $display("FAIL scoreboard_empty: got %0d entries, want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
